// File: rtl/msp430_rst_pkg.sv
// Shared types and constants for the MSP430 reset controller.
package msp430_rst_pkg;

  typedef enum logic [1:0] {
    POR_HOLD = 2'd0,
    PUC_HOLD = 2'd1,
    RUN      = 2'd2
  } rst_state_t;

  localparam int CAUSE_W   = 4;
  localparam int CAUSE_POR = 0;
  localparam int CAUSE_WDT = 1;
  localparam int CAUSE_SW  = 2;
  localparam int CAUSE_DBG = 3;

  // Counter must hold the larger of the two hold lengths without wrapping.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/msp430_rst_ctrl_if.sv
// Request/strobe inputs and reset/cause outputs of the reset controller.
interface msp430_rst_ctrl_if;
  import msp430_rst_pkg::*;

  logic               wdt_rst;
  logic               sw_rst;
  logic               dbg_rst;
  logic               cause_clr;
  logic               por_rst;
  logic               puc_rst;
  logic [CAUSE_W-1:0] rst_cause;

  modport master (
    output wdt_rst, sw_rst, dbg_rst, cause_clr,
    input  por_rst, puc_rst, rst_cause
  );

  modport slave (
    input  wdt_rst, sw_rst, dbg_rst, cause_clr,
    output por_rst, puc_rst, rst_cause
  );

endinterface

// File: rtl/msp430_rst_sync.sv
// Async-assert / sync-deassert reset synchroniser; sync_done rises after
// SYNC_STAGES clock edges with arst_n high.
module msp430_rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic arst_n,
  output logic sync_done
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) chain <= '0;
    else         chain <= {chain[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_done = chain[SYNC_STAGES-1];

endmodule

// File: rtl/msp430_rst_ctrl.sv
// MSP430 reset generator: stretches pin reset into POR/PUC and turns
// wdt/sw/dbg requests into PUC pulses. MSP430_RST_CAUSE_EN adds cause bits.
module msp430_rst_ctrl
  import msp430_rst_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int POR_CYCLES  = 16,
  parameter int PUC_CYCLES  = 4
) (
  input  logic               mclk,
  input  logic               reset_n,
  input  logic               scan_mode,
  input  logic               scan_rst_n,
  msp430_rst_ctrl_if.slave   rst_if
);

  localparam int             CNT_W    = cnt_width(POR_CYCLES, PUC_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] PUC_LAST = CNT_W'(PUC_CYCLES - 1);

  logic             arst_n;
  logic             sync_done;
  logic             req;
  rst_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic             por_q, por_nx;
  logic             puc_q, puc_nx;

  assign arst_n  = scan_mode ? scan_rst_n : reset_n;
  assign req     = rst_if.wdt_rst | rst_if.sw_rst | rst_if.dbg_rst;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  msp430_rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (mclk),
    .arst_n    (arst_n),
    .sync_done (sync_done)
  );

  always_ff @(posedge mclk or negedge arst_n) begin
    if (!arst_n) begin
      state <= POR_HOLD;
      cnt   <= '0;
      por_q <= 1'b1;
      puc_q <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      por_q <= por_nx;
      puc_q <= puc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    por_nx   = por_q;
    puc_nx   = puc_q;
    unique case (state)
      POR_HOLD: begin
        if (sync_done) begin
          if (cnt == POR_LAST) begin
            por_nx   = 1'b0;
            cnt_nx   = '0;
            state_nx = PUC_HOLD;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
      end
      PUC_HOLD: begin
        // A request while holding restarts the full PUC length.
        if (req) begin
          cnt_nx = '0;
        end else if (cnt == PUC_LAST) begin
          puc_nx   = 1'b0;
          cnt_nx   = '0;
          state_nx = RUN;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      RUN: begin
        if (req) begin
          puc_nx   = 1'b1;
          cnt_nx   = '0;
          state_nx = PUC_HOLD;
        end
      end
      default: state_nx = POR_HOLD;
    endcase
  end

  assign rst_if.por_rst = por_q;
  assign rst_if.puc_rst = puc_q;

`ifdef MSP430_RST_CAUSE_EN
  logic [CAUSE_W-1:0] cause_q;
  logic [CAUSE_W-1:0] cause_set;

  // Requests are only honoured (and recorded) once POR has released.
  always_comb begin
    cause_set = '0;
    if (state != POR_HOLD) begin
      cause_set[CAUSE_WDT] = rst_if.wdt_rst;
      cause_set[CAUSE_SW]  = rst_if.sw_rst;
      cause_set[CAUSE_DBG] = rst_if.dbg_rst;
    end
  end

  always_ff @(posedge mclk or negedge arst_n) begin
    if (!arst_n) cause_q <= CAUSE_W'(1) << CAUSE_POR;
    else         cause_q <= (rst_if.cause_clr ? '0 : cause_q) | cause_set;
  end

  assign rst_if.rst_cause = cause_q;
`else
  assign rst_if.rst_cause = '0;
`endif

endmodule
